mem_bist: RTL and testbench

MEM_BIST -- requirements
Module: mem_bist

---
 rtl/mem_bist.sv | 160 ++++++++++++++++
 tb/tb_mem_bist.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/mem_bist.sv
// March-style memory BIST: six elements (w0; r0w1; r1w0 ascending, r0w1; r1w0; r0 descending).
// Define MEM_BIST_FAIL_CAPTURE_EN to add fail_addr/fail_exp/fail_act first-mismatch capture.
module mem_bist #(
    parameter int DATA_W    = 8,
    parameter int MEM_SIZE  = 6,
    parameter int ADDR_SIZE = $clog2(MEM_SIZE) + 1
) (
    input  logic                 clock,
    input  logic                 reset_n,
    input  logic                 start,
    output logic                 busy,
    output logic                 done,
    output logic                 pass,
    output logic                 mem_write,
    output logic                 mem_read,
    output logic [ADDR_SIZE-1:0] mem_addr_w,
    output logic [ADDR_SIZE-1:0] mem_addr_r,
    output logic [DATA_W-1:0]    mem_datain,
    input  logic [DATA_W-1:0]    mem_dataout
`ifdef MEM_BIST_FAIL_CAPTURE_EN
    ,
    output logic [ADDR_SIZE-1:0] fail_addr,
    output logic [DATA_W-1:0]    fail_exp,
    output logic [DATA_W-1:0]    fail_act
`endif
);

    typedef enum logic [1:0] {IDLE, RUN, FLUSH, DONE} state_t;

    typedef struct packed {
        logic              vld;
        logic [DATA_W-1:0] exp;
    } cmp_t;

    localparam logic [ADDR_SIZE-1:0] LAST_ADDR = ADDR_SIZE'(MEM_SIZE - 1);
    localparam logic [2:0] E0 = 3'd0, E1 = 3'd1, E2 = 3'd2, E3 = 3'd3, E4 = 3'd4, E5 = 3'd5;

    state_t               state_q, state_d;
    logic [2:0]           elem_q, elem_d;
    logic [ADDR_SIZE-1:0] addr_q, addr_d;
    cmp_t                 cmp_q, cmp_d;
    logic                 err_q, err_d;

    logic el_rd, el_wr, el_wones, el_eones, el_desc;
    logic run, accept, mismatch, last_addr;

    always_comb begin
        el_rd    = (elem_q != E0);
        el_wr    = (elem_q != E5);
        el_wones = (elem_q == E1) || (elem_q == E3);
        el_eones = (elem_q == E2) || (elem_q == E4);
        el_desc  = (elem_q >= E3);
    end

    // All memory-side outputs decode straight from registered state.
    assign run        = (state_q == RUN);
    assign mem_write  = run && el_wr;
    assign mem_read   = run && el_rd;
    assign mem_addr_w = run ? addr_q : '0;
    assign mem_addr_r = run ? addr_q : '0;
    assign mem_datain = (run && el_wones) ? '1 : '0;

    assign busy   = (state_q == RUN) || (state_q == FLUSH);
    assign done   = (state_q == DONE);
    assign pass   = done && !err_q;
    assign accept = ((state_q == IDLE) || (state_q == DONE)) && start;

    assign mismatch  = cmp_q.vld && (mem_dataout != cmp_q.exp);
    assign last_addr = el_desc ? (addr_q == '0) : (addr_q == LAST_ADDR);

    always_comb begin
        state_d     = state_q;
        elem_d      = elem_q;
        addr_d      = addr_q;
        err_d       = err_q || mismatch;
        cmp_d.vld   = mem_read;
        cmp_d.exp   = (run && el_eones) ? '1 : '0;
        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    state_d = RUN;
                    elem_d  = E0;
                    addr_d  = '0;
                    err_d   = 1'b0;
                end
            end
            RUN: begin
                if (!last_addr) begin
                    addr_d = el_desc ? addr_q - ADDR_SIZE'(1) : addr_q + ADDR_SIZE'(1);
                end else if (elem_q == E5) begin
                    state_d = FLUSH;
                    elem_d  = E0;
                    addr_d  = '0;
                end else begin
                    // E2 -> E3 is where the sweep flips to descending.
                    elem_d = elem_q + 3'd1;
                    addr_d = (elem_q >= E2) ? LAST_ADDR : '0;
                end
            end
            FLUSH: state_d = DONE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            elem_q  <= E0;
            addr_q  <= '0;
            cmp_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            elem_q  <= elem_d;
            addr_q  <= addr_d;
            cmp_q   <= cmp_d;
            err_q   <= err_d;
        end
    end

`ifdef MEM_BIST_FAIL_CAPTURE_EN
    logic [ADDR_SIZE-1:0] cmp_addr_q;
    logic [ADDR_SIZE-1:0] fail_addr_q, fail_addr_d;
    logic [DATA_W-1:0]    fail_exp_q, fail_exp_d, fail_act_q, fail_act_d;

    always_comb begin
        fail_addr_d = fail_addr_q;
        fail_exp_d  = fail_exp_q;
        fail_act_d  = fail_act_q;
        if (accept) begin
            fail_addr_d = '0;
            fail_exp_d  = '0;
            fail_act_d  = '0;
        end else if (mismatch && !err_q) begin
            fail_addr_d = cmp_addr_q;
            fail_exp_d  = cmp_q.exp;
            fail_act_d  = mem_dataout;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            cmp_addr_q  <= '0;
            fail_addr_q <= '0;
            fail_exp_q  <= '0;
            fail_act_q  <= '0;
        end else begin
            cmp_addr_q  <= mem_addr_r;
            fail_addr_q <= fail_addr_d;
            fail_exp_q  <= fail_exp_d;
            fail_act_q  <= fail_act_d;
        end
    end

    assign fail_addr = fail_addr_q;
    assign fail_exp  = fail_exp_q;
    assign fail_act  = fail_act_q;
`endif

endmodule

// File: tb/tb_mem_bist.sv
// Bench for mem_bist: cycle model of the March sequence, memory models with an optional stuck bit.
module tb_mem_bist;
    localparam int DW  = 8;
    localparam int N   = 6;
    localparam int AW  = $clog2(N) + 1;
    localparam int N5  = 5;
    localparam int AW5 = $clog2(N5) + 1;

    logic clock = 0, reset_n = 0, start = 0, fault = 0;
    always #5 clock = ~clock;

    logic busy, done, pass, mw, mr;
    logic [AW-1:0] aw, ar;
    logic [DW-1:0] din, dout;
    logic busy5, done5, pass5, mw5, mr5;
    logic [AW5-1:0] aw5, ar5;
    logic [DW-1:0] din5, dout5;
`ifdef MEM_BIST_FAIL_CAPTURE_EN
    logic [AW-1:0] fa;   logic [DW-1:0] fe, fx;
    logic [AW5-1:0] fa5; logic [DW-1:0] fe5, fx5;
`endif

    mem_bist #(.DATA_W(DW), .MEM_SIZE(N)) dut (
        .clock(clock), .reset_n(reset_n), .start(start), .busy(busy), .done(done), .pass(pass),
        .mem_write(mw), .mem_read(mr), .mem_addr_w(aw), .mem_addr_r(ar),
        .mem_datain(din), .mem_dataout(dout)
`ifdef MEM_BIST_FAIL_CAPTURE_EN
        , .fail_addr(fa), .fail_exp(fe), .fail_act(fx)
`endif
    );

    mem_bist #(.DATA_W(DW), .MEM_SIZE(N5)) dut5 (
        .clock(clock), .reset_n(reset_n), .start(start), .busy(busy5), .done(done5), .pass(pass5),
        .mem_write(mw5), .mem_read(mr5), .mem_addr_w(aw5), .mem_addr_r(ar5),
        .mem_datain(din5), .mem_dataout(dout5)
`ifdef MEM_BIST_FAIL_CAPTURE_EN
        , .fail_addr(fa5), .fail_exp(fe5), .fail_act(fx5)
`endif
    );

    // Registered-read memories: read returns the old word, bit0 of word 3 optionally stuck at 1.
    logic [DW-1:0] mem6 [0:(1<<AW)-1];
    logic [DW-1:0] mem5 [0:(1<<AW5)-1];
    always @(posedge clock) begin
        if (mr) dout <= mem6[ar] | {{(DW-1){1'b0}}, (fault && ar == AW'(3))};
        if (mw) mem6[aw] <= din;
        if (mr5) dout5 <= mem5[ar5];
        if (mw5) mem5[aw5] <= din5;
    end

    int n_pass = 0, n_total = 0;
    task automatic chk(input string nm, input longint act, input longint exp);
        n_total++;
        if (act != exp) $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        else n_pass++;
    endtask

    // Model: cycle index since the accepting edge decides everything.
    int mcyc = 0;
    bit mbusy = 0, mdone = 0, mfault = 0;
    always @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            mbusy = 0; mdone = 0; mcyc = 0;
        end else if (!mbusy) begin
            if (start) begin
                mbusy = 1; mdone = 0; mcyc = 0; mfault = fault;
            end
        end else begin
            mcyc++;
            if (mcyc == 6 * N + 1) begin mbusy = 0; mdone = 1; end
        end
    end

    always @(negedge clock) begin
        int e, i, ea;
        bit ew, er;
        logic [DW-1:0] ed;
        ew = 0; er = 0; ea = 0; ed = '0;
        if (mbusy && mcyc < 6 * N) begin
            e  = mcyc / N;
            i  = mcyc % N;
            ea = (e < 3) ? i : N - 1 - i;
            ew = (e != 5);
            er = (e != 0);
            ed = (e == 1 || e == 3) ? '1 : '0;
        end
        chk("busy", busy, mbusy);
        chk("done", done, mdone);
        chk("pass", pass, mdone && !mfault);
        chk("mem_write", mw, ew);
        chk("mem_read", mr, er);
        chk("mem_addr_w", aw, ea);
        chk("mem_addr_r", ar, ea);
        chk("mem_datain", din, ed);
    end

    int trace5[$];
    always @(negedge clock) if (mw5 || mr5) trace5.push_back(int'(aw5));

    task automatic run_test(input int restart_at, input int reset_at,
                            output int edges, output int busyc, output int issc);
        int n;
        @(negedge clock) start = 1;
        @(negedge clock) start = 0;
        n = 0; busyc = 0; issc = 0; edges = -1;
        chk("done_drops_after_start", done, 0);
        while (!done && n < 200) begin
            if (n == reset_at) begin
                #2 reset_n = 0;
                #1;
                chk("rst_write", mw, 0);
                chk("rst_read", mr, 0);
                chk("rst_busy", busy, 0);
                chk("rst_done", done, 0);
                @(negedge clock) reset_n = 1;
                return;
            end
            if (busy) busyc++;
            if (mw || mr) issc++;
            @(posedge clock);
            n++;
            @(negedge clock);
            start = (n == restart_at);
        end
        start = 0;
        edges = n;
        if (n >= 200) chk("done_timeout", done, 1);
    endtask

    int ed, bc, ic;
    initial begin
        #1;
        chk("reset_busy", busy, 0);
        chk("reset_done", done, 0);
        chk("reset_pass", pass, 0);
        chk("reset_write", mw, 0);
        chk("reset_read", mr, 0);
        repeat (2) @(negedge clock);
        reset_n = 1;
        repeat (3) @(negedge clock);
        chk("idle_after_reset", busy, 0);

        // Fault-free run.
        run_test(-1, -1, ed, bc, ic);
        chk("t1_done_edge", ed, 37);
        chk("t1_busy_cycles", bc, 37);
        chk("t1_issue_cycles", ic, 36);
        chk("t1_pass", pass, 1);
        chk("t5_trace_len", trace5.size(), 30);
        for (int k = 0; k < 5; k++) begin
            chk("t5_e0_order", trace5[k], k);
            chk("t5_e3_order", trace5[15 + k], 4 - k);
        end
        foreach (trace5[k]) if (trace5[k] > 4) chk("t5_addr_range", trace5[k], 4);
        chk("t5_pass", pass5, 1);
        chk("t5_done", done5, 1);

        // Stuck bit at address 3.
        fault = 1;
        run_test(-1, -1, ed, bc, ic);
        chk("t2_done", done, 1);
        chk("t2_pass", pass, 0);
`ifdef MEM_BIST_FAIL_CAPTURE_EN
        chk("t2_fail_addr", fa, 3);
        chk("t2_fail_exp", fe, 8'h00);
        chk("t2_fail_act", fx, 8'h01);
`endif

        // Restart from DONE with the fault gone.
        fault = 0;
        run_test(-1, -1, ed, bc, ic);
        chk("t3_done_edge", ed, 37);
        chk("t3_pass", pass, 1);
`ifdef MEM_BIST_FAIL_CAPTURE_EN
        chk("t3_fail_addr", fa, 0);
        chk("t3_fail_exp", fe, 0);
        chk("t3_fail_act", fx, 0);
`endif

        // start during RUN is ignored.
        run_test(10, -1, ed, bc, ic);
        chk("t4_done_edge", ed, 37);
        chk("t4_pass", pass, 1);

        // Reset mid-run, then a clean full run.
        run_test(-1, 20, ed, bc, ic);
        repeat (2) @(negedge clock);
        chk("t5_idle_after_reset", busy, 0);
        run_test(-1, -1, ed, bc, ic);
        chk("t6_done_edge", ed, 37);
        chk("t6_pass", pass, 1);

        repeat (2) @(negedge clock);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
